bus_mux_reg: RTL and testbench

Parametrised, registered successor to the datapath bus multiplexer. It selects one of NUM_SRC source words onto the shared CPU bus using per-source drive enables, with fixed priority where the highest index wins. The bus word is registered: 1-cycle latency, with hold-when-idle behaviour. It also detects multiple-driver conflicts and keeps a sticky flag and a saturating count for debug. It sits between the register file / special registers (HI, LO, Z, PC, MDR, InPort, C) and every bus consumer.

---
 rtl/bus_mux_reg.sv | 115 +++++++++++
 tb/tb_bus_mux_reg.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mux_reg.sv
// Registered priority bus multiplexer: highest-index enabled source drives the bus one cycle later.
// Tracks multi-driver conflicts; define BUS_ONEHOT_ASSERT_EN to add a simulation-only one-hot check.
module bus_mux_reg #(
   parameter int WIDTH     = 32,
   parameter int NUM_SRC   = 24,
   parameter int CNT_W     = 8,
   parameter int HOLD_LAST = 1,
   localparam int SEL_W    = $clog2(NUM_SRC)
) (
   input  logic                     clock,
   input  logic                     clear,
   input  logic [NUM_SRC*WIDTH-1:0] src_data,
   input  logic [NUM_SRC-1:0]       src_out,
   input  logic                     conflict_clr,
   output logic [WIDTH-1:0]         bus_out,
   output logic                     bus_valid,
   output logic [SEL_W-1:0]         bus_sel,
   output logic                     conflict,
   output logic                     conflict_sticky,
   output logic [CNT_W-1:0]         conflict_count
);

   logic [WIDTH-1:0] bus_q,    bus_d;
   logic [SEL_W-1:0] sel_q,    sel_d;
   logic             valid_q,  valid_d;
   logic             conf_q,   conf_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] count_q,  count_d;

   logic             any_drv;
   logic             multi_drv;
   logic [SEL_W-1:0] win_idx;
   logic [WIDTH-1:0] win_data;

   // Ascending scan so the last enabled source seen (highest index) wins.
   always_comb begin
      any_drv   = 1'b0;
      multi_drv = 1'b0;
      win_idx   = '0;
      win_data  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (src_out[i]) begin
            multi_drv = multi_drv | any_drv;
            any_drv   = 1'b1;
            win_idx   = SEL_W'(i);
            win_data  = src_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      bus_d    = bus_q;
      sel_d    = sel_q;
      valid_d  = any_drv;
      conf_d   = multi_drv;
      sticky_d = sticky_q;
      count_d  = count_q;

      if (any_drv) begin
         bus_d = win_data;
         sel_d = win_idx;
      end else if (HOLD_LAST == 0) begin
         bus_d = '0;
         sel_d = '0;
      end

      // A new conflict on the same edge as conflict_clr restarts the count at one.
      if (multi_drv) begin
         sticky_d = 1'b1;
         if (conflict_clr)
            count_d = CNT_W'(1);
         else if (count_q != {CNT_W{1'b1}})
            count_d = count_q + CNT_W'(1);
      end else if (conflict_clr) begin
         sticky_d = 1'b0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         bus_q    <= '0;
         sel_q    <= '0;
         valid_q  <= 1'b0;
         conf_q   <= 1'b0;
         sticky_q <= 1'b0;
         count_q  <= '0;
      end else begin
         bus_q    <= bus_d;
         sel_q    <= sel_d;
         valid_q  <= valid_d;
         conf_q   <= conf_d;
         sticky_q <= sticky_d;
         count_q  <= count_d;
      end
   end

   assign bus_out         = bus_q;
   assign bus_sel         = sel_q;
   assign bus_valid       = valid_q;
   assign conflict        = conf_q;
   assign conflict_sticky = sticky_q;
   assign conflict_count  = count_q;

`ifdef BUS_ONEHOT_ASSERT_EN
`ifndef SYNTHESIS
   always @(posedge clock) begin
      if (!clear && ($countones(src_out) >= 2))
         $error("bus_mux_reg: multiple drivers at %0t, src_out=%h", $time, src_out);
   end
`endif
`else
`endif

endmodule

// File: tb/tb_bus_mux_reg.sv
// Bench for bus_mux_reg: a default instance (hold-last, 8-bit count) and a second one
// (drive-zero idle, 2-bit count) share stimulus and are checked against a reference model.
module tb_bus_mux_reg;

   localparam int W  = 32;
   localparam int NS = 24;

   logic            clock = 1'b0;
   logic            clear;
   logic [NS*W-1:0] src_data;
   logic [NS-1:0]   src_out;
   logic            conflict_clr;

   logic [W-1:0] bus_a, bus_b;
   logic         valid_a, valid_b;
   logic [4:0]   sel_a, sel_b;
   logic         conf_a, conf_b;
   logic         sticky_a, sticky_b;
   logic [7:0]   cnt_a;
   logic [1:0]   cnt_b;

   bus_mux_reg #(.WIDTH(W), .NUM_SRC(NS), .CNT_W(8), .HOLD_LAST(1)) u_hold (
      .clock(clock), .clear(clear), .src_data(src_data), .src_out(src_out),
      .conflict_clr(conflict_clr), .bus_out(bus_a), .bus_valid(valid_a), .bus_sel(sel_a),
      .conflict(conf_a), .conflict_sticky(sticky_a), .conflict_count(cnt_a));

   bus_mux_reg #(.WIDTH(W), .NUM_SRC(NS), .CNT_W(2), .HOLD_LAST(0)) u_zero (
      .clock(clock), .clear(clear), .src_data(src_data), .src_out(src_out),
      .conflict_clr(conflict_clr), .bus_out(bus_b), .bus_valid(valid_b), .bus_sel(sel_b),
      .conflict(conf_b), .conflict_sticky(sticky_b), .conflict_count(cnt_b));

   always #5 clock = ~clock;

   // Observed outputs gathered per instance (0 = hold-last, 1 = drive-zero).
   logic [W-1:0] o_bus[2];
   logic         o_valid[2], o_conf[2], o_sticky[2];
   int           o_sel[2], o_cnt[2];
   always_comb begin
      o_bus[0] = bus_a;   o_bus[1] = bus_b;
      o_valid[0] = valid_a; o_valid[1] = valid_b;
      o_conf[0] = conf_a;   o_conf[1] = conf_b;
      o_sticky[0] = sticky_a; o_sticky[1] = sticky_b;
      o_sel[0] = int'(sel_a); o_sel[1] = int'(sel_b);
      o_cnt[0] = int'(cnt_a); o_cnt[1] = int'(cnt_b);
   end

   // Reference model state per instance.
   logic [W-1:0] m_bus[2];
   logic         m_valid[2], m_conf[2], m_sticky[2];
   int           m_sel[2], m_cnt[2];
   int           m_max[2]  = '{255, 3};
   bit           m_hold[2] = '{1'b1, 1'b0};

   int n_tests = 0;
   int n_fail  = 0;

   function automatic void model_edge();
      int n, w;
      n = $countones(src_out);
      w = -1;
      for (int i = NS - 1; i >= 0; i--) begin
         if (src_out[i] && w < 0) w = i;
      end
      for (int d = 0; d < 2; d++) begin
         if (clear) begin
            m_bus[d] = '0; m_sel[d] = 0; m_valid[d] = 0;
            m_conf[d] = 0; m_sticky[d] = 0; m_cnt[d] = 0;
         end else begin
            if (n > 0) begin
               m_bus[d] = src_data[w*W +: W];
               m_sel[d] = w;
               m_valid[d] = 1;
            end else begin
               m_valid[d] = 0;
               if (!m_hold[d]) begin
                  m_bus[d] = '0;
                  m_sel[d] = 0;
               end
            end
            m_conf[d] = (n >= 2);
            if (n >= 2) begin
               m_sticky[d] = 1;
               m_cnt[d] = conflict_clr ? 1 : ((m_cnt[d] < m_max[d]) ? m_cnt[d] + 1 : m_max[d]);
            end else if (conflict_clr) begin
               m_sticky[d] = 0;
               m_cnt[d] = 0;
            end
         end
      end
   endfunction

   task automatic cycle();
      @(posedge clock);
      model_edge();
      #1;
   endtask

   function automatic logic [NS*W-1:0] rand_data();
      logic [NS*W-1:0] v;
      for (int i = 0; i < NS; i++) v[i*W +: W] = $urandom;
      return v;
   endfunction

   task automatic test_reset();
      clear = 1'b1; conflict_clr = 1'b0;
      src_out = '1;
      src_data = rand_data() | {NS{32'h1}};
      cycle();
      cycle();
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (o_bus[d] !== '0 || o_valid[d] !== 1'b0 || o_sel[d] != 0 || o_conf[d] !== 1'b0
             || o_sticky[d] !== 1'b0 || o_cnt[d] != 0) begin
            n_fail++;
            $display("FAIL reset[%0d]: bus=%h valid=%b sel=%0d conf=%b sticky=%b cnt=%0d, want all zero",
                     d, o_bus[d], o_valid[d], o_sel[d], o_conf[d], o_sticky[d], o_cnt[d]);
         end
      end
      clear = 1'b0; src_out = '0;
      cycle();
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (o_valid[d] !== 1'b0 || o_bus[d] !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle[%0d]: bus=%h valid=%b, want 0/0", d, o_bus[d], o_valid[d]);
         end
      end
   endtask

   task automatic test_single();
      src_out = '0; src_out[3] = 1'b1;
      src_data = rand_data();
      src_data[3*W +: W] = 32'hDEADBEEF;
      #2;
      n_tests++;
      if (bus_a !== 32'h0 || valid_a !== 1'b0) begin
         n_fail++;
         $display("FAIL single_same_cycle: bus=%h valid=%b, want 00000000/0", bus_a, valid_a);
      end
      cycle();
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (o_bus[d] !== 32'hDEADBEEF || o_sel[d] != 3 || o_valid[d] !== 1'b1 || o_conf[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL single[%0d]: bus=%h sel=%0d valid=%b conf=%b, want deadbeef/3/1/0",
                     d, o_bus[d], o_sel[d], o_valid[d], o_conf[d]);
         end
      end
   endtask

   task automatic test_idle();
      src_out = '0;
      src_data = rand_data();
      cycle();
      n_tests++;
      if (bus_a !== 32'hDEADBEEF || sel_a !== 5'd3 || valid_a !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_hold: bus=%h sel=%0d valid=%b, want deadbeef/3/0", bus_a, sel_a, valid_a);
      end
      n_tests++;
      if (bus_b !== 32'h0 || sel_b !== 5'd0 || valid_b !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_zero: bus=%h sel=%0d valid=%b, want 0/0/0", bus_b, sel_b, valid_b);
      end
   endtask

   task automatic test_conflict();
      src_out = '0; src_out[2] = 1'b1; src_out[20] = 1'b1;
      src_data = rand_data();
      src_data[2*W +: W]  = 32'h11111111;
      src_data[20*W +: W] = 32'h22222222;
      cycle();
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (o_bus[d] !== 32'h22222222 || o_sel[d] != 20 || o_conf[d] !== 1'b1
             || o_sticky[d] !== 1'b1 || o_cnt[d] != 1) begin
            n_fail++;
            $display("FAIL conflict[%0d]: bus=%h sel=%0d conf=%b sticky=%b cnt=%0d, want 22222222/20/1/1/1",
                     d, o_bus[d], o_sel[d], o_conf[d], o_sticky[d], o_cnt[d]);
         end
      end
      src_out = '0;
      cycle();
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (o_conf[d] !== 1'b0 || o_sticky[d] !== 1'b1 || o_cnt[d] != 1) begin
            n_fail++;
            $display("FAIL conflict_after[%0d]: conf=%b sticky=%b cnt=%0d, want 0/1/1",
                     d, o_conf[d], o_sticky[d], o_cnt[d]);
         end
      end
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 5; k++) begin
         src_out = '0; src_out[k] = 1'b1; src_out[k+10] = 1'b1;
         src_data = rand_data();
         cycle();
      end
      n_tests++;
      if (cnt_b !== 2'd3 || cnt_a !== 8'd6) begin
         n_fail++;
         $display("FAIL saturate: cnt_b=%0d cnt_a=%0d, want 3/6", cnt_b, cnt_a);
      end
      conflict_clr = 1'b1;
      src_out = 24'h000101;
      cycle();
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (o_cnt[d] != 1 || o_sticky[d] !== 1'b1 || o_conf[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_race[%0d]: cnt=%0d sticky=%b conf=%b, want 1/1/1",
                     d, o_cnt[d], o_sticky[d], o_conf[d]);
         end
      end
      src_out = 24'h000040;
      cycle();
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (o_cnt[d] != 0 || o_sticky[d] !== 1'b0 || o_conf[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_alone[%0d]: cnt=%0d sticky=%b conf=%b, want 0/0/0",
                     d, o_cnt[d], o_sticky[d], o_conf[d]);
         end
      end
      conflict_clr = 1'b0;
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < NS; i++) begin
         src_out = '0; src_out[i] = 1'b1;
         src_data = rand_data();
         clear = (i == 10);
         cycle();
         for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (i == 10) begin
               if (o_bus[d] !== '0 || o_valid[d] !== 1'b0 || o_sel[d] != 0) begin
                  n_fail++;
                  $display("FAIL mid_reset[%0d]: bus=%h valid=%b sel=%0d, want 0/0/0",
                           d, o_bus[d], o_valid[d], o_sel[d]);
               end
            end else if (o_sel[d] != i || o_valid[d] !== 1'b1 || o_bus[d] !== src_data[i*W +: W]) begin
               n_fail++;
               $display("FAIL stream[%0d] src %0d: sel=%0d valid=%b bus=%h, want %0d/1/%h",
                        d, i, o_sel[d], o_valid[d], o_bus[d], i, src_data[i*W +: W]);
            end
         end
      end
      clear = 1'b0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         case ($urandom_range(0, 3))
            0: src_out = '0;
            1: begin src_out = '0; src_out[$urandom_range(0, NS-1)] = 1'b1; end
            2: begin
               src_out = '0;
               src_out[$urandom_range(0, NS-1)] = 1'b1;
               src_out[$urandom_range(0, NS-1)] = 1'b1;
            end
            default: src_out = NS'($urandom);
         endcase
         src_data = rand_data();
         conflict_clr = ($urandom_range(0, 9) == 0);
         clear = ($urandom_range(0, 39) == 0);
         cycle();
         for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (o_bus[d] !== m_bus[d] || o_sel[d] != m_sel[d] || o_valid[d] !== m_valid[d]
                || o_conf[d] !== m_conf[d] || o_sticky[d] !== m_sticky[d] || o_cnt[d] != m_cnt[d]) begin
               n_fail++;
               $display("FAIL random[%0d] step %0d: bus=%h sel=%0d v=%b c=%b s=%b n=%0d, want %h/%0d/%b/%b/%b/%0d",
                        d, k, o_bus[d], o_sel[d], o_valid[d], o_conf[d], o_sticky[d], o_cnt[d],
                        m_bus[d], m_sel[d], m_valid[d], m_conf[d], m_sticky[d], m_cnt[d]);
            end
         end
      end
      clear = 1'b0; conflict_clr = 1'b0;
   endtask

   initial begin
      clear = 1'b1; conflict_clr = 1'b0; src_out = '0; src_data = '0;
      for (int d = 0; d < 2; d++) begin
         m_bus[d] = '0; m_sel[d] = 0; m_valid[d] = 0;
         m_conf[d] = 0; m_sticky[d] = 0; m_cnt[d] = 0;
      end
      test_reset();
      test_single();
      test_idle();
      test_conflict();
      test_saturation();
      test_mid_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
